line_steer_ctrl: RTL

- Consumes the per-frame line-tracker outputs `centroid_x`, `line_valid` and `line_lost` from the centroid stage.
- Runs a fixed-point PD steering law on the horizontal error, then converts the result into left/right motor duty cycles.
- A frame-counted state machine handles line loss: hold, then search, then stop.
- Drives two glitch-free PWM outputs to the motor driver.

---
 rtl/line_ctrl_pkg.sv | 28 ++
 rtl/pwm_gen.sv | 36 +++
 rtl/line_steer_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/line_ctrl_pkg.sv
// Shared FSM encoding, datapath widths and the signed clamp used by the
// line steering controller.
package line_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SEARCH = 2'd3
    } steer_state_t;

    localparam int ERR_W = 12;
    localparam int SUM_W = 24;

    function automatic logic signed [SUM_W-1:0] sat_signed(
        input logic signed [SUM_W-1:0] val,
        input logic signed [SUM_W-1:0] lo,
        input logic signed [SUM_W-1:0] hi
    );
        logic signed [SUM_W-1:0] res;
        res = val;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end
        return res;
    endfunction
endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator whose duty is only taken up at a period boundary,
// so a duty change never shortens or stretches the period in progress.
module pwm_gen #(
    parameter int  PWM_PERIOD = 1024,
    localparam int PWM_W      = $clog2(PWM_PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);
    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_next;
    logic [PWM_W-1:0] active_q;
    logic [PWM_W-1:0] active_next;
    logic             wrap;

    always_comb begin
        wrap        = (cnt_q == PWM_W'(PWM_PERIOD - 1));
        cnt_next    = wrap ? '0 : cnt_q + PWM_W'(1);
        active_next = wrap ? duty : active_q;
    end

    // Output is registered against the counter value it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= '0;
            pwm      <= 1'b0;
        end else begin
            cnt_q    <= cnt_next;
            active_q <= active_next;
            pwm      <= (cnt_next < active_next);
        end
    end
endmodule

// File: rtl/line_steer_ctrl.sv
// Line-following steering controller: two-stage PD pipeline on the centroid
// error, a frame-counted line-loss FSM and two period-synchronous PWM outputs.
module line_steer_ctrl
    import line_ctrl_pkg::*;
#(
    parameter int  IMG_W         = 640,
    parameter int  KP            = 4,
    parameter int  KD            = 2,
    parameter int  FRAC_SHIFT    = 3,
    parameter int  STEER_MAX     = 300,
    parameter int  BASE_DUTY     = 600,
    parameter int  PWM_PERIOD    = 1024,
    parameter int  HOLD_FRAMES   = 4,
    parameter int  SEARCH_FRAMES = 30,
    parameter int  SEARCH_STEER  = 250,
    parameter int  SEARCH_DUTY   = 300,
    localparam int PWM_W         = $clog2(PWM_PERIOD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    input  logic [10:0]        centroid_x,
    input  logic               line_valid,
    input  logic               line_lost,
    output logic signed [11:0] steer,
    output logic [PWM_W-1:0]   duty_left,
    output logic [PWM_W-1:0]   duty_right,
    output logic               cmd_valid,
    output logic [1:0]         state,
    output logic               pwm_left,
    output logic               pwm_right
);
    localparam int STEER_W = 12;
    localparam int CNT_W   = $clog2(HOLD_FRAMES + SEARCH_FRAMES + 1);
    localparam logic signed [SUM_W-1:0]   KP_S        = SUM_W'(KP);
    localparam logic signed [SUM_W-1:0]   KD_S        = SUM_W'(KD);
    localparam logic signed [SUM_W-1:0]   STEER_LIM   = SUM_W'(STEER_MAX);
    localparam logic signed [SUM_W-1:0]   BASE_S      = SUM_W'(BASE_DUTY);
    localparam logic signed [SUM_W-1:0]   SRCH_BASE_S = SUM_W'(SEARCH_DUTY);
    localparam logic signed [SUM_W-1:0]   DUTY_MAX    = SUM_W'(PWM_PERIOD - 1);
    localparam logic signed [STEER_W-1:0] SRCH_STEER  = STEER_W'(SEARCH_STEER);

    steer_state_t              state_q, state_next;
    logic [CNT_W-1:0]          lost_cnt_q, lost_cnt_next, lost_cnt_inc;
    logic                      s1_valid_q, s1_lost_q, frame_go;
    logic signed [ERR_W-1:0]   s1_err_q, prev_err_q, prev_eff;
    logic signed [ERR_W:0]     derr;
    logic signed [SUM_W-1:0]   pd_sum, pd_raw, pd_sat, base, steer_ext, left_full, right_full;
    logic signed [STEER_W-1:0] steer_q, steer_next;
    logic [PWM_W-1:0]          duty_left_q, duty_right_q, duty_left_next, duty_right_next;
    logic                      cmd_valid_q, load_duty, zero_duty;

    assign frame_go = run_en && s1_valid_q;

    // Stage 1: centre-referenced error and loss flag for the strobed frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lost_q  <= 1'b0;
            s1_err_q   <= '0;
        end else begin
            s1_valid_q <= line_valid && run_en;
            s1_lost_q  <= line_lost;
            s1_err_q   <= ERR_W'({1'b0, centroid_x}) - ERR_W'(IMG_W / 2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            lost_cnt_q <= '0;
        end else begin
            state_q    <= state_next;
            lost_cnt_q <= lost_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_q;
        lost_cnt_next = lost_cnt_q;
        lost_cnt_inc  = lost_cnt_q + CNT_W'(1);
        if (!run_en) begin
            state_next    = ST_STOP;
            lost_cnt_next = '0;
        end else if (s1_valid_q) begin
            if (!s1_lost_q) begin
                state_next    = ST_TRACK;
                lost_cnt_next = '0;
            end else begin
                case (state_q)
                    ST_TRACK: begin
                        state_next    = ST_HOLD;
                        lost_cnt_next = CNT_W'(1);
                    end
                    ST_HOLD: begin
                        if (lost_cnt_inc >= CNT_W'(HOLD_FRAMES)) begin
                            state_next    = ST_SEARCH;
                            lost_cnt_next = '0;
                        end else begin
                            lost_cnt_next = lost_cnt_inc;
                        end
                    end
                    ST_SEARCH: begin
                        if (lost_cnt_inc >= CNT_W'(SEARCH_FRAMES)) begin
                            state_next    = ST_STOP;
                            lost_cnt_next = '0;
                        end else begin
                            lost_cnt_next = lost_cnt_inc;
                        end
                    end
                    default: lost_cnt_next = '0;
                endcase
            end
        end
    end

    // Stage 2: PD law and duty mixing. Re-entering TRACK seeds the previous
    // error with the current one so the derivative term starts at zero.
    always_comb begin
        prev_eff  = (state_q == ST_TRACK) ? prev_err_q : s1_err_q;
        derr      = (ERR_W + 1)'(s1_err_q) - (ERR_W + 1)'(prev_eff);
        pd_sum    = KP_S * SUM_W'(s1_err_q) + KD_S * SUM_W'(derr);
        pd_raw    = pd_sum >>> FRAC_SHIFT;
        pd_sat    = sat_signed(pd_raw, -STEER_LIM, STEER_LIM);
        steer_next = steer_q;
        base       = BASE_S;
        load_duty  = 1'b0;
        zero_duty  = !run_en;
        if (!run_en) begin
            steer_next = '0;
        end else if (s1_valid_q) begin
            case (state_next)
                ST_TRACK: begin
                    steer_next = STEER_W'(pd_sat);
                    load_duty  = 1'b1;
                end
                ST_HOLD: ;
                ST_SEARCH: begin
                    steer_next = prev_err_q[ERR_W-1] ? -SRCH_STEER : SRCH_STEER;
                    base       = SRCH_BASE_S;
                    load_duty  = 1'b1;
                end
                default: begin
                    steer_next = '0;
                    zero_duty  = 1'b1;
                end
            endcase
        end
        steer_ext  = SUM_W'(steer_next);
        left_full  = sat_signed(base + steer_ext, '0, DUTY_MAX);
        right_full = sat_signed(base - steer_ext, '0, DUTY_MAX);
        duty_left_next  = zero_duty ? '0 : (load_duty ? PWM_W'(left_full)  : duty_left_q);
        duty_right_next = zero_duty ? '0 : (load_duty ? PWM_W'(right_full) : duty_right_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            steer_q      <= '0;
            duty_left_q  <= '0;
            duty_right_q <= '0;
            cmd_valid_q  <= 1'b0;
            prev_err_q   <= '0;
        end else begin
            steer_q      <= steer_next;
            duty_left_q  <= duty_left_next;
            duty_right_q <= duty_right_next;
            cmd_valid_q  <= frame_go;
            if (frame_go && !s1_lost_q) begin
                prev_err_q <= s1_err_q;
            end
        end
    end

    assign steer      = steer_q;
    assign duty_left  = duty_left_q;
    assign duty_right = duty_right_q;
    assign cmd_valid  = cmd_valid_q;
    assign state      = state_q;

    pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm_left (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_left_q),
        .pwm   (pwm_left)
    );

    pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm_right (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_right_q),
        .pwm   (pwm_right)
    );
endmodule
